// File: rtl/toothless_lsu_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : toothless_lsu_ctrl
// Purpose  : Load/store sequencer between the EX stage and the data-memory
//            bus (req/gnt/rvalid). It handles one load or store at a time and
//            stalls the core while that op is in flight. It formats byte
//            enables and store data, and it sign- or zero-extends load data
//            for the RF write port (RF_WP_A_SEL_LSU).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TIMEOUT_CYCLES : maximum number of cycles spent in REQ+RESP before the op
//                    is aborted with an error; 0 disables the timeout
//   CNT_WIDTH      : width of the timeout counter (must hold TIMEOUT_CYCLES)
// Ports
//   clk_i, rst_i          : clock, asynchronous active-high reset
//   req_i                 : EX holds a load/store (level, held while busy_o)
//   we_i / size_i /
//   unsigned_i            : store flag, access size (funct3[1:0]), zero-extend
//   addr_i / wdata_i      : effective address, store data (rs2)
//   busy_o                : pipeline stall request
//   done_o                : 1-cycle completion pulse, rdata_o/err_o valid
//   rdata_o / err_o       : extended load data / bus error, timeout, misalign
//   data_*                : data-memory bus master interface
// Configuration
//   TOOTHLESS_LSU_MISALIGN_EXC_EN : when defined, a misaligned half or word
//     access completes at once with err_o set and issues no bus request.
//     When undefined, the low address bits that the access size does not use
//     are dropped.
// ============================================================================
module toothless_lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Counter value seen during the last cycle allowed in REQ/RESP.
  localparam logic [CNT_WIDTH-1:0] TO_LAST =
    CNT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  state_e                state_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [1:0]            size_q;
  logic                  unsigned_q;
  logic [1:0]            off_q;        // captured addr[1:0]
  logic                  data_req_q;
  logic [31:0]           data_addr_q;
  logic                  data_we_q;    // also the captured store flag
  logic [3:0]            data_be_q;
  logic [31:0]           data_wdata_q;
  logic                  done_q;
  logic                  err_q;
  logic [31:0]           rdata_q;

  logic                  accept;
  logic                  misalign;
  logic                  timeout_hit;
  logic [CNT_WIDTH-1:0]  cnt_d;
  logic [3:0]            be_d;
  logic [31:0]           wdata_d;
  logic [1:0]            ld_off;
  logic [31:0]           ld_shift;
  logic [31:0]           load_d;

  // done_q blocks acceptance so the op that just completed (req_i is still
  // high in the done cycle) is not accepted a second time.
  assign accept = (state_q == ST_IDLE) & req_i & ~done_q;
  assign busy_o = (state_q != ST_IDLE) | (req_i & ~done_q);

`ifdef TOOTHLESS_LSU_MISALIGN_EXC_EN
  assign misalign = ((size_i == 2'b01) & addr_i[0]) |
                    (size_i[1] & (addr_i[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q >= TO_LAST);
  // The counter saturates so that a late grant cannot wrap it.
  assign cnt_d       = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);

  // Store formatting: replicate the store data across all lanes so that the
  // byte enables alone select the target bytes.
  always_comb begin
    be_d    = 4'b0000;
    wdata_d = 32'h0;
    unique case (size_i)
      2'b00: begin
        be_d    = 4'b0001 << addr_i[1:0];
        wdata_d = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_d    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{wdata_i[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = wdata_i;
      end
    endcase
  end

  // Load extraction: move the addressed lane down to bit 0, then extend it.
  always_comb begin
    ld_off = 2'b00;
    unique case (size_q)
      2'b00:   ld_off = off_q;
      2'b01:   ld_off = {off_q[1], 1'b0};
      default: ld_off = 2'b00;
    endcase
  end

  assign ld_shift = data_rdata_i >> {ld_off, 3'b000};

  always_comb begin
    load_d = ld_shift;
    unique case (size_q)
      2'b00:   load_d = {{24{~unsigned_q & ld_shift[7]}},  ld_shift[7:0]};
      2'b01:   load_d = {{16{~unsigned_q & ld_shift[15]}}, ld_shift[15:0]};
      default: load_d = ld_shift;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      size_q       <= 2'b00;
      unsigned_q   <= 1'b0;
      off_q        <= 2'b00;
      data_req_q   <= 1'b0;
      data_addr_q  <= 32'h0;
      data_we_q    <= 1'b0;
      data_be_q    <= 4'b0000;
      data_wdata_q <= 32'h0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= 32'h0;
    end else begin
      // Completion outputs are a single-cycle pulse.
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;

      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            size_q     <= size_i;
            unsigned_q <= unsigned_i;
            off_q      <= addr_i[1:0];
            data_we_q  <= we_i;
            cnt_q      <= '0;
            if (misalign) begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              state_q      <= ST_REQ;
              data_req_q   <= 1'b1;
              data_addr_q  <= {addr_i[31:2], 2'b00};
              data_be_q    <= be_d;
              data_wdata_q <= wdata_d;
            end
          end
        end

        ST_REQ: begin
          cnt_q <= cnt_d;
          // A grant in the timeout cycle still completes the handshake.
          if (data_gnt_i) begin
            state_q    <= ST_RESP;
            data_req_q <= 1'b0;
          end else if (timeout_hit) begin
            state_q    <= ST_IDLE;
            data_req_q <= 1'b0;
            done_q     <= 1'b1;
            err_q      <= 1'b1;
          end
        end

        ST_RESP: begin
          cnt_q <= cnt_d;
          if (data_rvalid_i) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
            err_q   <= data_err_i;
            rdata_q <= (data_we_q | data_err_i) ? 32'h0 : load_d;
          end else if (timeout_hit) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end
        end

        default: begin
          state_q    <= ST_IDLE;
          data_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign done_o       = done_q;
  assign err_o        = err_q;
  assign rdata_o      = rdata_q;
  assign data_req_o   = data_req_q;
  assign data_addr_o  = data_addr_q;
  assign data_we_o    = data_we_q;
  assign data_be_o    = data_be_q;
  assign data_wdata_o = data_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_toothless_lsu_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_toothless_lsu_ctrl
// Purpose  : Self-checking bench for toothless_lsu_ctrl. Each op is described
//            by its grant delay and response delay. A reference model
//            computes the completion cycle, the timeout abort point, the bus
//            fields and the extended result from those delays. Directed cases
//            are followed by randomized ops.
// Revision : 1.0 - initial release
// ============================================================================
module tb_toothless_lsu_ctrl;

  localparam int unsigned TO = 4;
  localparam int          NEVER = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, we, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        busy, done, err;
  logic [31:0] rdata;
  logic        dreq, dgnt, dwe, drvalid, derr;
  logic [31:0] daddr, dwdata, drdata;
  logic [3:0]  dbe;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  toothless_lsu_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .size_i(size),
    .unsigned_i(uns), .addr_i(addr), .wdata_i(wdata), .busy_o(busy),
    .done_o(done), .rdata_o(rdata), .err_o(err), .data_req_o(dreq),
    .data_gnt_i(dgnt), .data_addr_o(daddr), .data_we_o(dwe),
    .data_be_o(dbe), .data_wdata_o(dwdata), .data_rvalid_i(drvalid),
    .data_rdata_i(drdata), .data_err_i(derr)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // ---------------- reference model (rules of the bus format) -------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic int lane_off(input logic [1:0] sz, input logic [1:0] a);
    if (sz == 2'd0) return int'(a);
    if (sz == 2'd1) return int'(a) & 2;
    return 0;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] m;
    m = 4'h0;
    for (int i = 0; i < nbytes(sz); i++) m[lane_off(sz, a) + i] = 1'b1;
    return m;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] w);
    logic [31:0] r;
    int n;
    n = nbytes(sz);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input bit u,
                                             input logic [1:0] a, input logic [31:0] rd);
    logic [63:0] v, span;
    int n;
    n    = nbytes(sz);
    span = 64'd1 << (8 * n);
    v    = ({32'h0, rd} >> (8 * lane_off(sz, a))) & (span - 64'd1);
    if (!u && (((v >> (8 * n - 1)) & 64'd1) != 64'd0)) v = v - span;
    return v[31:0];
  endfunction

  function automatic bit model_misal(input logic [1:0] sz, input logic [1:0] a);
`ifdef TOOTHLESS_LSU_MISALIGN_EXC_EN
    return (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a != 2'd0);
`else
    return 1'b0;
`endif
  endfunction

  // Runs one op whose first req_i cycle is the current cycle (k = 0). The
  // grant arrives g cycles after data_req_o first rises, and rvalid arrives
  // r cycles after the response phase starts.
  task automatic run_op(input string nm, input bit w, input logic [1:0] sz,
                        input bit u, input logic [31:0] a, input logic [31:0] wd,
                        input int g, input int r, input logic [31:0] rd,
                        input bit berr);
    bit mis;
    int gc, vc, ab, d, req_last;
    logic [31:0] exp_rd;
    bit exp_err;

    mis = model_misal(sz, a[1:0]);
    gc  = 1 + g;
    vc  = 2 + g + r;
    ab  = -1;
    if (!mis && TO != 0) begin
      for (int c = int'(TO); c <= vc; c++) begin
        if (c == gc || c == vc) continue;
        ab = c;
        break;
      end
    end
    if (mis) begin
      d = 1; req_last = 0; exp_err = 1'b1; exp_rd = 32'h0;
    end else if (ab >= 0) begin
      d = ab + 1; req_last = (ab < gc) ? ab : gc;
      exp_err = 1'b1; exp_rd = 32'h0;
    end else begin
      d = vc + 1; req_last = gc; exp_err = berr;
      exp_rd = (w || berr) ? 32'h0 : model_load(sz, u, a[1:0], rd);
    end

    req = 1'b1; we = w; size = sz; uns = u; addr = a; wdata = wd;
    for (int k = 0; k <= d; k++) begin
      dgnt    = (!mis && k == gc && k <= req_last);
      drvalid = (!mis && ab < 0 && k == vc);
      drdata  = drvalid ? rd : $urandom;
      derr    = drvalid ? berr : 1'($urandom_range(0, 1));
      @(negedge clk);
      check($sformatf("%s busy@%0d", nm, k), {31'h0, busy}, {31'h0, k < d});
      check($sformatf("%s dreq@%0d", nm, k), {31'h0, dreq},
            {31'h0, (k >= 1 && k <= req_last)});
      check($sformatf("%s done@%0d", nm, k), {31'h0, done}, {31'h0, k == d});
      if (k >= 1 && k <= req_last) begin
        check($sformatf("%s addr@%0d", nm, k), daddr, {a[31:2], 2'b00});
        check($sformatf("%s be@%0d", nm, k), {28'h0, dbe}, {28'h0, model_be(sz, a[1:0])});
        check($sformatf("%s wdata@%0d", nm, k), dwdata, model_wdata(sz, wd));
        check($sformatf("%s we@%0d", nm, k), {31'h0, dwe}, {31'h0, w});
      end
      if (k == d) begin
        check($sformatf("%s rdata", nm), rdata, exp_rd);
        check($sformatf("%s err", nm), {31'h0, err}, {31'h0, exp_err});
      end
      @(posedge clk); #1;
    end
  endtask

  // Idle cycles with no op; optional stray gnt/rvalid must be ignored.
  task automatic idle(input string nm, input int n, input bit stray);
    for (int k = 0; k < n; k++) begin
      req = 1'b0; dgnt = stray; drvalid = stray;
      drdata = $urandom; derr = 1'($urandom_range(0, 1));
      @(negedge clk);
      check($sformatf("%s idle busy@%0d", nm, k), {31'h0, busy}, 32'h0);
      check($sformatf("%s idle done@%0d", nm, k), {31'h0, done}, 32'h0);
      check($sformatf("%s idle dreq@%0d", nm, k), {31'h0, dreq}, 32'h0);
      @(posedge clk); #1;
    end
  endtask

  task automatic check_zero_outputs(input string nm);
    check({nm, " busy"},  {31'h0, busy}, 32'h0);
    check({nm, " done"},  {31'h0, done}, 32'h0);
    check({nm, " err"},   {31'h0, err},  32'h0);
    check({nm, " rdata"}, rdata, 32'h0);
    check({nm, " dreq"},  {31'h0, dreq}, 32'h0);
    check({nm, " daddr"}, daddr, 32'h0);
    check({nm, " dwe"},   {31'h0, dwe},  32'h0);
    check({nm, " dbe"},   {28'h0, dbe},  32'h0);
    check({nm, " dwdata"}, dwdata, 32'h0);
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'd0; uns = 1'b0;
    addr = 32'h0; wdata = 32'h0; dgnt = 1'b0; drvalid = 1'b0;
    drdata = 32'h0; derr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases.
    run_op("LW",      1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0);
    run_op("LB",      1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'h0, 0, 0, 32'h8012_3456, 1'b0);
    run_op("LBU",     1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'h0, 0, 0, 32'h8012_3456, 1'b0);
    idle("gap", 1, 1'b0);
    run_op("SH",      1'b1, 2'd1, 1'b0, 32'h0000_0102, 32'h1234_ABCD, 3, 0, 32'h5555_5555, 1'b0);
    run_op("LH err",  1'b0, 2'd1, 1'b0, 32'h0000_0100, 32'h0, 0, 0, 32'hFFFF_FFFF, 1'b1);
    run_op("LW tmo",  1'b0, 2'd2, 1'b0, 32'h0000_0200, 32'h0, NEVER, 0, 32'h0, 1'b0);
    idle("late", 2, 1'b1);
    run_op("RSP tmo", 1'b0, 2'd0, 1'b1, 32'h0000_0301, 32'h0, 0, 5, 32'h0, 1'b0);
    run_op("LW mis",  1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'h0, 0, 0, 32'hCAFE_F00D, 1'b0);
    run_op("SW mis",  1'b1, 2'd3, 1'b0, 32'h0000_0407, 32'h89AB_CDEF, 1, 1, 32'h0, 1'b0);

    // Asynchronous reset in the middle of an op: no completion follows.
    req = 1'b1; we = 1'b0; size = 2'd2; addr = 32'h0000_0500; dgnt = 1'b0;
    drvalid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req = 1'b0;
    #1 rst = 1'b1;
    #1 check_zero_outputs("async rst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    idle("post rst", 2, 1'b0);

    // Randomized ops, some back-to-back, some with stray bus handshakes.
    for (int i = 0; i < 40; i++) begin
      run_op($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
             $urandom, int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
             $urandom, ($urandom_range(0, 7) == 0));
      idle($sformatf("rnd%0d", i), int'($urandom_range(0, 2)),
           1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
